// File: rtl/uart_can_frame_packer.sv
// UART-to-CAN frame packer: gathers received bytes into frames of up to MAX_BYTES,
// closes them on count, idle timeout or flush, and queues them for can_tx.
module uart_can_frame_packer #(
    parameter int MAX_BYTES = 8,
    parameter int ID_W      = 12,
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 1024,
    parameter int DROP_W    = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [7:0]                 rx_byte,
    input  logic                       rx_valid,
    input  logic                       flush,
    input  logic [ID_W-1:0]            cfg_id,
    output logic                       frame_valid,
    input  logic                       frame_ready,
    output logic [ID_W-1:0]            frame_id,
    output logic [63:0]                frame_data,
    output logic [3:0]                 frame_dlc,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int IDLE_W = $clog2(TIMEOUT);

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [63:0]     data;
        logic [3:0]      dlc;
    } frame_t;

    logic [3:0]        byte_cnt_q, byte_cnt_d;
    logic [63:0]       asm_q, asm_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [63:0]       asm_data;
    logic [3:0]        asm_cnt;
    logic              close;

    frame_t            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    frame_t            head_q, head_d, new_frame;
    logic              valid_q, valid_d, ovf_q, ovf_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              full, push, pop;

    // Assembly view including any same-cycle byte, so every close path sees the same frame.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a missed branch would infer a latch.
        asm_data = asm_q;
        for (int k = 0; k < MAX_BYTES; k++) begin
            if (rx_valid && byte_cnt_q == 4'(k)) asm_data[63-8*k -: 8] = rx_byte;
        end
        asm_cnt = byte_cnt_q + 4'(rx_valid);
        close   = (rx_valid && byte_cnt_q == 4'(MAX_BYTES-1))
               || (flush && asm_cnt != 4'd0)
               || (!rx_valid && byte_cnt_q != 4'd0 && idle_q == IDLE_W'(TIMEOUT-1));

        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        idle_d     = idle_q;
        if (close) begin
            byte_cnt_d = '0;
            asm_d      = '0;
            idle_d     = '0;
        end else if (rx_valid) begin
            byte_cnt_d = asm_cnt;
            asm_d      = asm_data;
            idle_d     = '0;
        end else if (byte_cnt_q != 4'd0) begin
            idle_d = idle_q + 1'b1;
        end
    end

    always_comb begin
        new_frame.id   = cfg_id;
        new_frame.data = asm_data;
        new_frame.dlc  = asm_cnt;

        full  = level_q == LVL_W'(DEPTH);
        pop   = valid_q && frame_ready;
        push  = close && (!full || pop);
        ovf_d = close && full && !pop;

        drop_d = drop_q;
        if (ovf_d && drop_q != '1) drop_d = drop_q + 1'b1;

        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        valid_d  = level_d != '0;

        // The head register is reloaded from the new frame when it lands in an otherwise empty queue.
        head_d = head_q;
        if (push && level_q == LVL_W'(pop)) head_d = new_frame;
        else if (pop && level_d != '0)     head_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            byte_cnt_q <= '0;
            asm_q      <= '0;
            idle_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            head_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            idle_q     <= idle_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            head_q     <= head_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    // NOTE: the frame storage has no reset; the pointers and level alone define which entries are live.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= new_frame;
    end

    assign frame_valid = valid_q;
    assign frame_id    = head_q.id;
    assign frame_data  = head_q.data;
    assign frame_dlc   = head_q.dlc;
    assign fifo_level  = level_q;
    assign overflow    = ovf_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_uart_can_frame_packer.sv
// Self-checking bench for uart_can_frame_packer: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_uart_can_frame_packer;

    localparam int MAX_BYTES = 8;
    localparam int ID_W      = 12;
    localparam int DEPTH     = 4;
    localparam int TIMEOUT   = 16;
    localparam int DROP_W    = 2;

    logic              clock = 1'b0;
    logic              reset;
    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              flush;
    logic [ID_W-1:0]   cfg_id;
    logic              frame_valid;
    logic              frame_ready;
    logic [ID_W-1:0]   frame_id;
    logic [63:0]       frame_data;
    logic [3:0]        frame_dlc;
    logic [$clog2(DEPTH):0] fifo_level;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    always #5 clock = ~clock;

    uart_can_frame_packer #(
        .MAX_BYTES(MAX_BYTES), .ID_W(ID_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .DROP_W(DROP_W)
    ) dut (
        .clock(clock), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid), .flush(flush),
        .cfg_id(cfg_id), .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_id(frame_id),
        .frame_data(frame_data), .frame_dlc(frame_dlc), .fifo_level(fifo_level),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [63:0]     data;
        logic [3:0]      dlc;
    } frm_t;

    // Reference model: pending bytes, queued frames, drop tally, time of the last byte.
    frm_t       exp_q[$];
    logic [7:0] part_q[$];
    int         cyc = 0;
    int         last_rx_cyc = 0;
    int         exp_drops = 0;
    bit         exp_ovf = 1'b0;
    int         ovf_pulses = 0;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_part();
        logic [63:0] d = '0;
        foreach (part_q[k]) d[63-8*k -: 8] = part_q[k];
        return d;
    endfunction

    task automatic compare_outputs();
        check("valid", 64'(frame_valid), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check("id", 64'(frame_id), 64'(exp_q[0].id));
            check("data", frame_data, exp_q[0].data);
            check("dlc", 64'(frame_dlc), 64'(exp_q[0].dlc));
        end
        check("level", 64'(fifo_level), 64'(exp_q.size()));
        check("overflow", 64'(overflow), 64'(exp_ovf));
        check("drop_cnt", 64'(drop_cnt), 64'(exp_drops));
    endtask

    task automatic step(input bit rv, input logic [7:0] b, input bit fl, input bit rdy);
        bit   pop, close, full;
        int   pre_n;
        frm_t f;
        rx_valid = rv; rx_byte = b; flush = fl; frame_ready = rdy;
        @(posedge clock);
        cyc++;
        pre_n = part_q.size();
        close = !rv && pre_n > 0 && (cyc - last_rx_cyc) == TIMEOUT;
        if (rv) begin
            part_q.push_back(b);
            last_rx_cyc = cyc;
        end
        if (part_q.size() == MAX_BYTES) close = 1'b1;
        if (fl && part_q.size() > 0) close = 1'b1;
        f.id   = cfg_id;
        f.data = pack_part();
        f.dlc  = 4'(part_q.size());
        full   = exp_q.size() == DEPTH;
        pop    = exp_q.size() > 0 && rdy;
        exp_ovf = 1'b0;
        if (pop) void'(exp_q.pop_front());
        if (close) begin
            if (!full || pop) exp_q.push_back(f);
            else begin
                exp_ovf = 1'b1;
                if (exp_drops < (1 << DROP_W) - 1) exp_drops++;
            end
            part_q.delete();
        end
        #1;
        if (overflow) ovf_pulses++;
        compare_outputs();
    endtask

    task automatic do_reset();
        rx_valid = 1'b0; flush = 1'b0; frame_ready = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #2;
        check("rst_valid", 64'(frame_valid), 64'd0);
        check("rst_id", 64'(frame_id), 64'd0);
        check("rst_data", frame_data, 64'd0);
        check("rst_dlc", 64'(frame_dlc), 64'd0);
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        exp_q.delete();
        part_q.delete();
        exp_drops = 0;
        exp_ovf = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic send_frame(input bit rdy);
        for (int k = 0; k < MAX_BYTES; k++) step(1'b1, 8'($urandom), 1'b0, rdy);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && exp_q.size() > 0; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
        check("drain_empty", 64'(fifo_level), 64'd0);
    endtask

    initial begin
        int n;
        int dens;
        reset = 1'b1; rx_byte = '0; rx_valid = 1'b0; flush = 1'b0; frame_ready = 1'b0; cfg_id = '0;
        do_reset();

        // Full frame: 8 consecutive bytes
        cfg_id = 12'h20D;
        for (int k = 0; k < 8; k++) step(1'b1, 8'(8'h11 * (k + 1)), 1'b0, 1'b1);
        check("full_valid", 64'(frame_valid), 64'd1);
        check("full_data", frame_data, 64'h1122334455667788);
        check("full_dlc", 64'(frame_dlc), 64'd8);
        check("full_id", 64'(frame_id), 64'h20D);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Idle timeout on a 3-byte partial frame
        cfg_id = 12'h123;
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0);
        step(1'b1, 8'hCC, 1'b0, 1'b0);
        n = 0;
        while (!frame_valid && n < 40) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            n++;
        end
        check("timeout_cycles", 64'(n), 64'(TIMEOUT));
        check("timeout_data", frame_data, 64'hAABBCC0000000000);
        check("timeout_dlc", 64'(frame_dlc), 64'd3);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Byte arriving exactly when the timeout would fire
        step(1'b1, 8'h01, 1'b0, 1'b1);
        step(1'b1, 8'h02, 1'b0, 1'b1);
        repeat (TIMEOUT - 1) step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h03, 1'b0, 1'b1);
        check("race_no_close", 64'(frame_valid), 64'd0);
        repeat (TIMEOUT - 2) step(1'b0, 8'h00, 1'b0, 1'b1);
        check("race_restart", 64'(frame_valid), 64'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("race_dlc", 64'(frame_dlc), 64'd3);
        check("race_data", frame_data, 64'h0102030000000000);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Flush with a same-cycle byte, then flush on empty assembly
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        check("flush_dlc", 64'(frame_dlc), 64'd1);
        check("flush_data", frame_data, 64'h5A00000000000000);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("flush_empty", 64'(frame_valid), 64'd0);

        // Back-pressure: five full frames into a four-entry queue
        ovf_pulses = 0;
        for (int f = 0; f < 5; f++) begin
            cfg_id = 12'(12'h300 + f);
            send_frame(1'b0);
        end
        check("bp_level", 64'(fifo_level), 64'd4);
        check("bp_ovf_pulses", 64'(ovf_pulses), 64'd1);
        check("bp_drop_cnt", 64'(drop_cnt), 64'd1);
        for (int f = 0; f < 3; f++) send_frame(1'b0);
        check("drop_saturate", 64'(drop_cnt), 64'd3);
        // Close coinciding with a pop while full must be accepted
        for (int k = 0; k < MAX_BYTES - 1; k++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b1);
        check("full_pushpop_level", 64'(fifo_level), 64'd4);
        check("full_pushpop_drop", 64'(drop_cnt), 64'd3);
        drain();

        // Reset in the middle of a frame
        step(1'b1, 8'hF1, 1'b0, 1'b1);
        step(1'b1, 8'hF2, 1'b0, 1'b1);
        step(1'b1, 8'hF3, 1'b0, 1'b1);
        do_reset();
        cfg_id = 12'h0AB;
        for (int k = 0; k < 8; k++) step(1'b1, 8'(k + 1), 1'b0, 1'b0);
        check("post_rst_data", frame_data, 64'h0102030405060708);
        check("post_rst_dlc", 64'(frame_dlc), 64'd8);
        drain();

        // Random traffic with varying byte density and back-pressure
        dens = 50;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) dens = (i / 250) % 3 == 0 ? 4 : ((i / 250) % 3 == 1 ? 50 : 95);
            if ($urandom_range(0, 31) == 0) cfg_id = 12'($urandom);
            step(1'($urandom_range(0, 99) < dens), 8'($urandom),
                 1'($urandom_range(0, 29) == 0), 1'($urandom_range(0, 9) < 6));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
